// File: rtl/collision_scan_pkg.sv
// collision_scan_pkg: shared default sizes, coordinate widths and scan FSM encoding
package collision_scan_pkg;
   localparam int DEF_MAX_ENEMY = 4;
   localparam int DEF_MAX_ENEMY_BULLET = 4;
   localparam int DEF_MAX_PLAYER_BULLET = 4;
   localparam int DEF_X_W = 10;
   localparam int DEF_Y_W = 9;
   localparam int DEF_BULLET_WIDTH = 4;
   localparam int DEF_BULLET_HEIGHT = 8;
   localparam int DEF_ENEMY_WIDTH = 32;
   localparam int DEF_ENEMY_HEIGHT = 32;
   localparam int DEF_PLAYER_WIDTH = 32;
   localparam int DEF_PLAYER_HEIGHT = 16;
   localparam int DEF_PLAYER_Y = 440;
   typedef enum logic [2:0] {IDLE, SCAN_EB_PB, SCAN_PB_EN, SCAN_EB_PL, DONE} scanState_t;
endpackage

// File: rtl/collision_scan_box_overlap.sv
// box_overlap: strict axis-aligned box overlap of two {x, y} positions with runtime box sizes
module box_overlap
   import collision_scan_pkg::*;
#(
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W
) (
   input  logic [X_W+Y_W-1:0] aPos,
   input  logic [X_W+Y_W-1:0] bPos,
   input  logic [X_W-1:0]     aW,
   input  logic [Y_W-1:0]     aH,
   input  logic [X_W-1:0]     bW,
   input  logic [Y_W-1:0]     bH,
   output logic               overlap
);
   logic [X_W:0] ax, bx, axEnd, bxEnd;
   logic [Y_W:0] ay, by, ayEnd, byEnd;
   assign ax = {1'b0, aPos[X_W+Y_W-1:Y_W]};
   assign bx = {1'b0, bPos[X_W+Y_W-1:Y_W]};
   assign ay = {1'b0, aPos[Y_W-1:0]};
   assign by = {1'b0, bPos[Y_W-1:0]};
   // one extra bit keeps far-edge sums from wrapping at the screen border
   assign axEnd = ax + {1'b0, aW};
   assign bxEnd = bx + {1'b0, bW};
   assign ayEnd = ay + {1'b0, aH};
   assign byEnd = by + {1'b0, bH};
   assign overlap = (ax < bxEnd) && (bx < axEnd) && (ay < byEnd) && (by < ayEnd);
endmodule

// File: rtl/collision_scan.sv
// collision_scan: per-frame collision engine testing one object pair per clock on a shared comparator
module collision_scan
   import collision_scan_pkg::*;
#(
   parameter int MAX_ENEMY = DEF_MAX_ENEMY,
   parameter int MAX_ENEMY_BULLET = DEF_MAX_ENEMY_BULLET,
   parameter int MAX_PLAYER_BULLET = DEF_MAX_PLAYER_BULLET,
   parameter int X_W = DEF_X_W,
   parameter int Y_W = DEF_Y_W,
   parameter int BULLET_WIDTH = DEF_BULLET_WIDTH,
   parameter int BULLET_HEIGHT = DEF_BULLET_HEIGHT,
   parameter int ENEMY_WIDTH = DEF_ENEMY_WIDTH,
   parameter int ENEMY_HEIGHT = DEF_ENEMY_HEIGHT,
   parameter int PLAYER_WIDTH = DEF_PLAYER_WIDTH,
   parameter int PLAYER_HEIGHT = DEF_PLAYER_HEIGHT,
   parameter int PLAYER_Y = DEF_PLAYER_Y
) (
   input  logic                                   i_Clk,
   input  logic                                   i_Rst_n,
   input  logic                                   i_Start,
   input  logic [MAX_ENEMY-1:0]                   i_EnemyState,
   input  logic [MAX_ENEMY_BULLET-1:0]            i_EnemyBulletState,
   input  logic [MAX_PLAYER_BULLET-1:0]           i_PlayerBulletState,
   input  logic                                   i_PlayerState,
   input  logic [MAX_ENEMY*(X_W+Y_W)-1:0]         i_EnemyPosition,
   input  logic [MAX_ENEMY_BULLET*(X_W+Y_W)-1:0]  i_EnemyBulletPosition,
   input  logic [MAX_PLAYER_BULLET*(X_W+Y_W)-1:0] i_PlayerBulletPosition,
   input  logic [X_W-1:0]                         i_PlayerX,
   output logic                                   o_Busy,
   output logic                                   o_Done,
   output logic [MAX_ENEMY-1:0]                   o_EnemyKill,
   output logic [MAX_ENEMY_BULLET-1:0]            o_EnemyBulletKill,
   output logic [MAX_PLAYER_BULLET-1:0]           o_PlayerBulletKill,
   output logic                                   o_PlayerHit,
   output logic [$clog2(MAX_ENEMY+1)-1:0]         o_KillCount
);
   localparam int POS_W = X_W + Y_W;
   localparam int MAX_EP = (MAX_ENEMY > MAX_PLAYER_BULLET) ? MAX_ENEMY : MAX_PLAYER_BULLET;
   localparam int MAX_N = (MAX_EP > MAX_ENEMY_BULLET) ? MAX_EP : MAX_ENEMY_BULLET;
   localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam int KC_W = $clog2(MAX_ENEMY + 1);
   scanState_t state, nextState;
   logic [CNT_W-1:0] outer, inner;
   logic [MAX_ENEMY-1:0] enAct, enSel;
   logic [MAX_ENEMY_BULLET-1:0] ebAct, ebSel;
   logic [MAX_PLAYER_BULLET-1:0] pbAct, pbSel;
   logic [MAX_ENEMY*POS_W-1:0] enPos;
   logic [MAX_ENEMY_BULLET*POS_W-1:0] ebPos;
   logic [MAX_PLAYER_BULLET*POS_W-1:0] pbPos;
   logic [X_W-1:0] playerX, aW, bW;
   logic [Y_W-1:0] aH, bH;
   logic [POS_W-1:0] aPos, bPos;
   logic playerAlive, pairOk, overlap, hit, innerLast, outerLast;
   logic [KC_W-1:0] killSum;
   assign o_Busy = state inside {SCAN_EB_PB, SCAN_PB_EN, SCAN_EB_PL};
   assign o_Done = state == DONE;
   assign innerLast = (state == SCAN_EB_PB) ? inner == CNT_W'(MAX_PLAYER_BULLET - 1) : inner == CNT_W'(MAX_ENEMY - 1);
   assign outerLast = (state == SCAN_PB_EN) ? outer == CNT_W'(MAX_PLAYER_BULLET - 1) : outer == CNT_W'(MAX_ENEMY_BULLET - 1);
   assign ebSel = MAX_ENEMY_BULLET'(1) << outer;
   assign pbSel = MAX_PLAYER_BULLET'(1) << ((state == SCAN_PB_EN) ? outer : inner);
   assign enSel = MAX_ENEMY'(1) << inner;
   assign hit = pairOk && overlap;
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) state <= IDLE;
      else state <= nextState;
   end
   always_comb begin
      nextState = state;
      case (state)
         IDLE:       nextState = i_Start ? SCAN_EB_PB : IDLE;
         SCAN_EB_PB: nextState = (innerLast && outerLast) ? SCAN_PB_EN : SCAN_EB_PB;
         SCAN_PB_EN: nextState = (innerLast && outerLast) ? SCAN_EB_PL : SCAN_PB_EN;
         SCAN_EB_PL: nextState = outerLast ? DONE : SCAN_EB_PL;
         default:    nextState = IDLE;
      endcase
   end
   // comparator operands per phase; a pair only counts while both sides are live
   always_comb begin
      aPos = '0;
      bPos = '0;
      aW = '0;
      aH = '0;
      bW = '0;
      bH = '0;
      pairOk = 1'b0;
      case (state)
         SCAN_EB_PB: begin
            aPos = ebPos[int'(outer)*POS_W +: POS_W];
            bPos = pbPos[int'(inner)*POS_W +: POS_W];
            {aW, aH, bW, bH} = {X_W'(BULLET_WIDTH), Y_W'(BULLET_HEIGHT), X_W'(BULLET_WIDTH), Y_W'(BULLET_HEIGHT)};
            pairOk = |(ebAct & ebSel & ~o_EnemyBulletKill) && |(pbAct & pbSel & ~o_PlayerBulletKill);
         end
         SCAN_PB_EN: begin
            aPos = pbPos[int'(outer)*POS_W +: POS_W];
            bPos = enPos[int'(inner)*POS_W +: POS_W];
            {aW, aH, bW, bH} = {X_W'(BULLET_WIDTH), Y_W'(BULLET_HEIGHT), X_W'(ENEMY_WIDTH), Y_W'(ENEMY_HEIGHT)};
            pairOk = |(pbAct & pbSel & ~o_PlayerBulletKill) && |(enAct & enSel & ~o_EnemyKill);
         end
         SCAN_EB_PL: begin
            aPos = ebPos[int'(outer)*POS_W +: POS_W];
            bPos = {playerX, Y_W'(PLAYER_Y)};
            {aW, aH, bW, bH} = {X_W'(BULLET_WIDTH), Y_W'(BULLET_HEIGHT), X_W'(PLAYER_WIDTH), Y_W'(PLAYER_HEIGHT)};
            pairOk = playerAlive && |(ebAct & ebSel & ~o_EnemyBulletKill);
         end
         default: pairOk = 1'b0;
      endcase
   end
   always_comb begin
      killSum = '0;
      for (int i = 0; i < MAX_ENEMY; i++) killSum = killSum + KC_W'(o_EnemyKill[i]);
   end
   box_overlap #(.X_W(X_W), .Y_W(Y_W)) uOverlap (
      .aPos(aPos), .bPos(bPos), .aW(aW), .aH(aH), .bW(bW), .bH(bH), .overlap(overlap)
   );
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         {outer, inner, enAct, ebAct, pbAct, enPos, ebPos, pbPos, playerX, playerAlive} <= '0;
         {o_EnemyKill, o_EnemyBulletKill, o_PlayerBulletKill, o_PlayerHit, o_KillCount} <= '0;
      end else if (state == IDLE && i_Start) begin
         {enAct, ebAct, pbAct, playerAlive} <= {i_EnemyState, i_EnemyBulletState, i_PlayerBulletState, i_PlayerState};
         {enPos, ebPos, pbPos, playerX} <= {i_EnemyPosition, i_EnemyBulletPosition, i_PlayerBulletPosition, i_PlayerX};
         {outer, inner} <= '0;
         {o_EnemyKill, o_EnemyBulletKill, o_PlayerBulletKill, o_PlayerHit, o_KillCount} <= '0;
      end else if (state == SCAN_EB_PB || state == SCAN_PB_EN) begin
         inner <= innerLast ? '0 : inner + CNT_W'(1);
         outer <= innerLast ? (outerLast ? '0 : outer + CNT_W'(1)) : outer;
         if (hit && state == SCAN_EB_PB) o_EnemyBulletKill <= o_EnemyBulletKill | ebSel;
         if (hit && state == SCAN_PB_EN) o_EnemyKill <= o_EnemyKill | enSel;
         if (hit) o_PlayerBulletKill <= o_PlayerBulletKill | pbSel;
      end else if (state == SCAN_EB_PL) begin
         outer <= outerLast ? '0 : outer + CNT_W'(1);
         if (hit) o_EnemyBulletKill <= o_EnemyBulletKill | ebSel;
         if (hit) o_PlayerHit <= 1'b1;
         if (outerLast) o_KillCount <= killSum;
      end
   end
endmodule
